// File: rtl/tile_load_ctrl.sv
// Tile-load fetch controller: turns a load command into one AXI read request
// and streams the returned beats into the operand tile buffer.
module tile_load_ctrl #(
    parameter int DATA_W    = 256,
    parameter int MAX_BURST = 16,
    parameter int BUF_AW    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mat,
    input  logic [1:0]        rc,
    input  logic [1:0]        dtype,
    input  logic [31:0]       base_a,
    input  logic [31:0]       base_b,
    input  logic [31:0]       base_c,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [31:0]       req_base,
    output logic [2:0]        req_sel,
    output logic              req_issend,
    output logic [31:0]       req_bits,
    output logic [4:0]        req_burst_num,
    output logic [7:0]        req_burst_size,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_burst_id,
    input  logic              in_finish,
    output logic              buf_we,
    output logic [2:0]        buf_sel,
    output logic [BUF_AW-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      sel_q, sel_d;
    logic [31:0]     base_q, base_d;
    logic [31:0]     bits_q, bits_d;
    logic [4:0]      bnum_q, bnum_d;
    logic [7:0]      bsize_q, bsize_d;
    logic [BUF_AW:0] beats_q, beats_d;
    logic [BUF_AW:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [31:0] elems_c, width_c, bits_c, beats_c, bsize_c, bnum_c;
    logic        legal_c, last_c;

    // Beat id is informational only and never steers the controller.
    logic unused_burst_id;
    assign unused_burst_id = ^in_burst_id;

    always_comb begin
        elems_c = 32'd256;
        unique case (mat)
            2'd0: elems_c = (rc == 2'd0) ? 32'd512 :
                            (rc == 2'd1) ? 32'd256 : 32'd128;
            2'd1: elems_c = (rc == 2'd0) ? 32'd128 :
                            (rc == 2'd1) ? 32'd256 : 32'd512;
            default: elems_c = 32'd256;
        endcase
        // The C tile holds the FP32/INT32 accumulator regardless of dtype.
        width_c = (mat == 2'd2) ? 32'd32 : (32'd32 >> dtype);
        bits_c  = elems_c * width_c;
        beats_c = bits_c / 32'(DATA_W);
        bsize_c = (beats_c < 32'(MAX_BURST)) ? beats_c : 32'(MAX_BURST);
        bnum_c  = (beats_c > 32'(MAX_BURST)) ? beats_c / 32'(MAX_BURST)
                                             : 32'd1;
        legal_c = (mat != 2'd3) && (rc != 2'd3);
    end

    assign last_c = (cnt_q == beats_q - 1'b1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        base_d  = base_q;
        bits_d  = bits_q;
        bnum_d  = bnum_q;
        bsize_d = bsize_q;
        beats_d = beats_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && legal_c) begin
                    state_d = S_REQ;
                    sel_d   = 3'b100 >> mat;
                    base_d  = (mat == 2'd0) ? base_a :
                              (mat == 2'd1) ? base_b : base_c;
                    bits_d  = bits_c;
                    bnum_d  = bnum_c[4:0];
                    bsize_d = bsize_c[7:0];
                    beats_d = beats_c[BUF_AW:0];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (start) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_REQ: begin
                if (req_ready) state_d = S_RECV;
            end
            S_RECV: begin
                if (in_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_c) state_d = S_DONE;
                end
                // A finish that arrives with the last beat is normal.
                if (in_finish && !(in_valid && last_c)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            base_q  <= '0;
            bits_q  <= '0;
            bnum_q  <= '0;
            bsize_q <= '0;
            beats_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            base_q  <= base_d;
            bits_q  <= bits_d;
            bnum_q  <= bnum_d;
            bsize_q <= bsize_d;
            beats_q <= beats_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign req_valid      = (state_q == S_REQ);
    assign req_base       = base_q;
    assign req_sel        = sel_q;
    assign req_issend     = 1'b0;
    assign req_bits       = bits_q;
    assign req_burst_num  = bnum_q;
    assign req_burst_size = bsize_q;

    assign buf_we    = (state_q == S_RECV) && in_valid;
    assign buf_sel   = sel_q;
    assign buf_addr  = cnt_q[BUF_AW-1:0];
    assign buf_wdata = buf_we ? in_data : '0;

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign err  = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_tile_load_ctrl.sv
// Directed and randomized bench for tile_load_ctrl with a table-driven
// reference model of the request sizing and beat bookkeeping.
module tb_tile_load_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   mat, rc, dtype;
    logic [31:0]  base_a, base_b, base_c;
    logic         req_valid, req_ready, req_issend;
    logic [31:0]  req_base, req_bits;
    logic [2:0]   req_sel, buf_sel;
    logic [4:0]   req_burst_num;
    logic [7:0]   req_burst_size;
    logic         in_valid, in_finish;
    logic [255:0] in_data;
    logic [31:0]  in_burst_id;
    logic         buf_we, busy, done, err;
    logic [5:0]   buf_addr;
    logic [255:0] buf_wdata;

    int passed = 0;
    int total  = 0;

    tile_load_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mat(mat), .rc(rc), .dtype(dtype),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_sel(req_sel),
        .req_issend(req_issend), .req_bits(req_bits),
        .req_burst_num(req_burst_num),
        .req_burst_size(req_burst_size),
        .in_valid(in_valid), .in_data(in_data),
        .in_burst_id(in_burst_id), .in_finish(in_finish),
        .buf_we(buf_we), .buf_sel(buf_sel),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Shape table lookup and size arithmetic straight from the tile rules.
    function automatic int model_elems(input int m, input int r);
        int a_tab[3] = '{512, 256, 128};
        int b_tab[3] = '{128, 256, 512};
        if (m == 0) return a_tab[r];
        if (m == 1) return b_tab[r];
        return 256;
    endfunction

    function automatic int model_width(input int m, input int d);
        int w_tab[4] = '{32, 16, 8, 4};
        return (m == 2) ? 32 : w_tab[d];
    endfunction

    task automatic do_load(input int m, input int r, input int d,
                           input int rdy_dly, input int gap_pct,
                           input int fin_at, input bit req_beats);
        int eb, beats, bsz, bnum, k, cyc;
        logic [2:0]  esel;
        logic [31:0] ebase;
        logic [255:0] dat;
        bit legal, ended, efin, v, fin;
        legal = (m != 3) && (r != 3);
        start = 1'b1;
        mat   = 2'(m);
        rc    = 2'(r);
        dtype = 2'(d);
        @(posedge clk); #1;
        start = 1'b0;
        if (!legal) begin
            @(negedge clk);
            chk("ill_done", 256'(done), 256'(1));
            chk("ill_err", 256'(err), 256'(1));
            chk("ill_reqv", 256'(req_valid), 256'(0));
            @(posedge clk); #1;
            chk("ill_idle", 256'({busy, done, err}), 256'(0));
            return;
        end
        eb    = model_elems(m, r) * model_width(m, d);
        beats = eb / 256;
        bsz   = (beats < 16) ? beats : 16;
        bnum  = beats / bsz;
        esel  = (m == 0) ? 3'b100 : (m == 1) ? 3'b010 : 3'b001;
        ebase = (m == 0) ? base_a : (m == 1) ? base_b : base_c;
        for (int i = 0; i <= rdy_dly; i++) begin
            req_ready = (i == rdy_dly);
            in_valid  = req_beats ? 1'b1 : 1'($urandom_range(1));
            in_data   = rnd256();
            @(negedge clk);
            chk("req_valid", 256'(req_valid), 256'(1));
            chk("req_fields",
                256'({req_base, req_sel, req_issend, req_bits,
                      req_burst_num, req_burst_size}),
                256'({ebase, esel, 1'b0, 32'(eb), 5'(bnum), 8'(bsz)}));
            chk("req_no_we", 256'(buf_we), 256'(0));
            @(posedge clk); #1;
        end
        req_ready = 1'b0;
        k = 0; cyc = 0; ended = 0; efin = 0;
        while (!ended && cyc < 400) begin
            fin = (fin_at >= 0) && (fin_at < beats) && (k == fin_at);
            v   = fin ? 1'b0 : ($urandom_range(99) >= gap_pct);
            dat = rnd256();
            in_valid    = v;
            in_data     = dat;
            in_burst_id = $urandom;
            in_finish   = fin || (v && k == beats - 1 && fin_at == beats);
            @(negedge clk);
            chk("beat_we", 256'(buf_we), 256'(v));
            if (v) begin
                chk("beat_addr", 256'(buf_addr), 256'(k));
                chk("beat_data", buf_wdata, dat);
                chk("beat_sel", 256'(buf_sel), 256'(esel));
                k++;
            end
            if (fin) efin = 1;
            ended = fin || (k == beats);
            @(posedge clk); #1;
            cyc++;
        end
        if (!ended) chk("recv_timeout", 256'(k), 256'(beats));
        in_valid  = 1'b1;
        in_finish = 1'b0;
        in_data   = rnd256();
        @(negedge clk);
        chk("done", 256'(done), 256'(1));
        chk("done_err", 256'(err), 256'(efin));
        chk("extra_no_we", 256'(buf_we), 256'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_idle", 256'({busy, done, err}), 256'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mat = 0; rc = 0; dtype = 0;
        base_a = 32'h0; base_b = 32'h1000_0040; base_c = 32'h2000_0080;
        req_ready = 1'b0; in_valid = 1'b1; in_data = rnd256();
        in_burst_id = 0; in_finish = 1'b0;
        #12;
        chk("rst_outs",
            256'({req_valid, busy, done, err, buf_we, req_bits, req_sel,
                  req_burst_num, req_burst_size, buf_addr}), 256'(0));
        chk("rst_wdata", buf_wdata, 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ignore", 256'({buf_we, busy}), 256'(0));
        in_valid = 1'b0;

        do_load(0, 0, 1, 0, 0, -1, 0);
        do_load(1, 0, 3, 0, 0, -1, 0);
        do_load(2, 1, 2, 0, 40, -1, 0);
        do_load(0, 2, 0, 5, 0, -1, 1);
        do_load(3, 0, 0, 0, 0, -1, 0);
        do_load(0, 3, 0, 0, 0, -1, 0);
        do_load(2, 1, 2, 0, 0, 10, 0);
        do_load(1, 2, 0, 1, 20, 64, 0);

        start = 1'b1; mat = 2'd0; rc = 2'd1; dtype = 2'd0;
        req_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        req_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outs",
            256'({req_valid, busy, done, err, buf_we, buf_addr, req_sel,
                  buf_sel, req_bits}), 256'(0));
        chk("arst_wdata", buf_wdata, 256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_idle", 256'({buf_we, busy}), 256'(0));
        in_valid = 1'b0;
        do_load(0, 0, 0, 0, 25, -1, 0);

        for (int t = 0; t < 10; t++) begin
            base_a = $urandom; base_b = $urandom; base_c = $urandom;
            do_load(($urandom_range(9) == 0) ? 3 : $urandom_range(2),
                    ($urandom_range(9) == 0) ? 3 : $urandom_range(2),
                    $urandom_range(3), $urandom_range(3),
                    $urandom_range(50),
                    ($urandom_range(4) == 0) ? $urandom_range(1) : -1, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tile_load_ctrl.md
Name: tile_load_ctrl

Overview:
- Fetch controller that sits directly upstream of the systolic control FSM.
- Serves the READ_C / LOAD_A / LOAD_B phases: turns a tile-load command (matrix, shape code, data type) into a single AXI read request, then collects the returned 256-bit beats into the operand tile buffer.
- Reports completion to the systolic FSM with a one-cycle done pulse.

Parameters:
- DATA_W, 256, AXI beat width and buffer word width in bits.
- MAX_BURST, 16, maximum beats per burst.
- BUF_AW, 6, tile-buffer word address width (64 words = largest tile).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load command strobe; sampled only in IDLE.
- mat  in  2  matrix select: 0=A, 1=B, 2=C; 3 is illegal.
- rc  in  2  shape code: 0/1/2 per matrix shape table; 3 is illegal.
- dtype  in  2  0=FP32, 1=FP16, 2=INT8, 3=INT4.
- base_a, base_b, base_c  in  32 each  byte base addresses.
- req_valid  out  1  AXI read request valid.
- req_ready  in  1  AXI request accepted.
- req_base  out  32  request byte address.
- req_sel  out  3  100=A, 010=B, 001=C.
- req_issend  out  1  always 0 (read).
- req_bits  out  32  total bits requested.
- req_burst_num  out  5  number of bursts.
- req_burst_size  out  8  beats per burst.
- in_valid  in  1  return beat valid.
- in_data  in  DATA_W  return beat payload.
- in_burst_id  in  32  burst index of the beat; informational only.
- in_finish  in  1  AXI marks transfer complete.
- buf_we  out  1  tile-buffer write enable.
- buf_sel  out  3  target buffer, same encoding as req_sel.
- buf_addr  out  BUF_AW  word address.
- buf_wdata  out  DATA_W  word data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; all outputs 0; beat counter 0. Reset mid-transfer aborts immediately and drops any buffered state. Beats arriving after reset release are ignored in IDLE.
- Element count:
  - A, rc 0/1/2 → 512/256/128.
  - B, rc 0/1/2 → 128/256/512.
  - C → 256 for any legal rc.
- Element width: FP32=32, FP16=16, INT8=8, INT4=4. For mat=C the width is forced to 32 regardless of dtype, since the accumulator is FP32/INT32.
- Size arithmetic:
  - bits = elems × width.
  - beats = bits / DATA_W; every legal combination is an exact multiple, minimum 2 beats, maximum 64.
  - burst_size = min(beats, MAX_BURST).
  - burst_num = beats / burst_size.
- State machine:
  - IDLE, start=1 with legal mat/rc: latch all fields, go to REQ.
  - IDLE, start=1 with mat=3 or rc=3: go to DONE with an error flag; no request is issued.
  - REQ: req_valid=1; all req_* fields are stable while waiting. On req_valid & req_ready, go to RECV the next cycle.
  - RECV:
    - Each in_valid writes in_data at buf_addr=count in the same cycle; buf_we is combinational from in_valid, and the address comes from the registered count. Then count increments.
    - The beat with count=beats−1 moves to DONE.
    - Beats arriving beyond the expected total are never written.
    - in_finish before the last beat moves to DONE with an error flag.
    - in_finish coincident with the last beat is normal completion.
    - in_burst_id is ignored.
  - DONE: done=1 for exactly one cycle; err=1 in the same cycle if the error flag is set. Then go to IDLE and clear count.
- start outside IDLE is ignored.
- Minimum turnaround: start → req_valid is 1 cycle.
- Last beat → done is 1 cycle; done → next start accepted is 1 cycle.

Test Plan:
- A load, mat=0, rc=0, dtype=FP16, base_a=0x0, req_ready immediate:
  - Request fields: req_bits=8192, burst_size=16, burst_num=2, req_sel=100.
  - 32 beats are written to addr 0..31; done fires 1 cycle after the 32nd beat; err=0.
- B load, mat=1, rc=0, dtype=INT4: req_bits=512, burst_size=2, burst_num=1; 2 writes; done.
- C load, mat=2, rc=1, dtype=INT8: width forced to 32 → req_bits=8192, 32 beats; a gapped in_valid pattern leaves addresses contiguous.
- Backpressure: req_ready held low for 5 cycles → req_valid and all fields hold; beats during REQ are not written.
- Errors:
  - rc=3 → done and err pulse 1 cycle after start; req_valid is never asserted.
  - in_finish after beat 10 of 32 → done and err; no further buf_we.
- rst_n asserted in the middle of RECV → all outputs 0 asynchronously; a subsequent clean A load completes normally with addresses starting at 0.
